// File: rtl/serializador_8bit.sv
// Parallel-in / serial-out transmitter: captures a word on carregar and shifts it
// out one bit per habilita tick, with registered busy/done status.
module serializador_8bit #(
  parameter int LARGURA      = 8,
  parameter bit MSB_PRIMEIRO = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] entrada,
  input  logic               carregar,
  input  logic               habilita,
  output logic               saida_serial,
  output logic               ocupado,
  output logic               fim
);

  localparam int CW = $clog2(LARGURA + 1);
  localparam logic [CW-1:0] UM = CW'(1);
  localparam logic [CW-1:0] CARGA = CW'(LARGURA);

  typedef enum logic {
    OCIOSO    = 1'b0,
    TRANSMITE = 1'b1
  } estado_t;

  estado_t            estado_r, estado_s;
  logic [LARGURA-1:0] shift_r, shift_s;
  logic [CW-1:0]      count_r, count_s;
  logic               saida_r, saida_s;
  logic               ocupado_r, ocupado_s;
  logic               fim_r, fim_s;

  // Moves the next bit to transmit into the output position of the shift register.
  function automatic logic [LARGURA-1:0] desloca(input logic [LARGURA-1:0] v);
    if (MSB_PRIMEIRO) begin
      desloca = {v[LARGURA-2:0], 1'b0};
    end else begin
      desloca = {1'b0, v[LARGURA-1:1]};
    end
  endfunction

  function automatic logic bit_frente(input logic [LARGURA-1:0] v);
    if (MSB_PRIMEIRO) begin
      bit_frente = v[LARGURA-1];
    end else begin
      bit_frente = v[0];
    end
  endfunction

  // State and output registers; reset aborts any transfer without a done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r  <= OCIOSO;
      shift_r   <= {LARGURA{1'b0}};
      count_r   <= {CW{1'b0}};
      saida_r   <= 1'b0;
      ocupado_r <= 1'b0;
      fim_r     <= 1'b0;
    end else begin
      estado_r  <= estado_s;
      shift_r   <= shift_s;
      count_r   <= count_s;
      saida_r   <= saida_s;
      ocupado_r <= ocupado_s;
      fim_r     <= fim_s;
    end
  end

  // Next-state logic; output values are computed one cycle ahead so they leave registered.
  always_comb begin
    estado_s  = estado_r;
    shift_s   = shift_r;
    count_s   = count_r;
    saida_s   = saida_r;
    ocupado_s = ocupado_r;
    fim_s     = 1'b0;
    case (estado_r)
      OCIOSO: begin
        saida_s   = 1'b0;
        ocupado_s = 1'b0;
        if (carregar) begin
          shift_s   = entrada;
          count_s   = CARGA;
          saida_s   = bit_frente(entrada);
          ocupado_s = 1'b1;
          estado_s  = TRANSMITE;
        end else begin
          estado_s  = OCIOSO;
        end
      end
      TRANSMITE: begin
        if (habilita) begin
          if (count_r > UM) begin
            shift_s = desloca(shift_r);
            count_s = count_r - UM;
            saida_s = bit_frente(desloca(shift_r));
          end else begin
            estado_s  = OCIOSO;
            shift_s   = {LARGURA{1'b0}};
            count_s   = {CW{1'b0}};
            saida_s   = 1'b0;
            ocupado_s = 1'b0;
            fim_s     = 1'b1;
          end
        end else begin
          estado_s = TRANSMITE;
        end
      end
      default: begin
        estado_s  = OCIOSO;
        saida_s   = 1'b0;
        ocupado_s = 1'b0;
      end
    endcase
  end

  assign saida_serial = saida_r;
  assign ocupado      = ocupado_r;
  assign fim          = fim_r;

endmodule

// File: tb/tb_serializador_8bit.sv
// Directed bench for serializador_8bit: MSB-first and LSB-first instances share all
// inputs; outputs are checked as {saida_serial, ocupado, fim} one step after each edge.
module tb_serializador_8bit;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] entrada;
  logic       carregar;
  logic       habilita;
  logic       saida_m, ocupado_m, fim_m;
  logic       saida_l, ocupado_l, fim_l;

  int vectors = 0;
  int miscompares = 0;

  serializador_8bit #(.LARGURA(8), .MSB_PRIMEIRO(1'b1)) dut_msb (
    .clock(clock), .reset(reset), .entrada(entrada), .carregar(carregar),
    .habilita(habilita), .saida_serial(saida_m), .ocupado(ocupado_m), .fim(fim_m)
  );

  serializador_8bit #(.LARGURA(8), .MSB_PRIMEIRO(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .entrada(entrada), .carregar(carregar),
    .habilita(habilita), .saida_serial(saida_l), .ocupado(ocupado_l), .fim(fim_l)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (saida,ocupado,fim) at %0t", tag, obs, exp, $time);
    end
  endtask

  // Checks cycles 1..8 of a transfer already loaded at the previous edge, then the fim cycle.
  task automatic check_word(input string tag, input logic [7:0] pat);
    for (int c = 1; c <= 8; c++) begin
      chk({tag, "_msb"}, {saida_m, ocupado_m, fim_m}, {pat[8-c], 1'b1, 1'b0});
      chk({tag, "_lsb"}, {saida_l, ocupado_l, fim_l}, {pat[c-1], 1'b1, 1'b0});
      step();
    end
    chk({tag, "_fim_msb"}, {saida_m, ocupado_m, fim_m}, 3'b001);
    chk({tag, "_fim_lsb"}, {saida_l, ocupado_l, fim_l}, 3'b001);
  endtask

  initial begin
    logic [7:0] pat;

    // 1: reset dominates randomly toggling inputs
    reset = 1'b1; entrada = 8'h00; carregar = 1'b0; habilita = 1'b0;
    for (int i = 0; i < 6; i++) begin
      entrada  = 8'($urandom);
      carregar = 1'($urandom);
      habilita = 1'($urandom);
      step();
      chk("reset_msb", {saida_m, ocupado_m, fim_m}, 3'b000);
      chk("reset_lsb", {saida_l, ocupado_l, fim_l}, 3'b000);
    end
    reset = 1'b0; carregar = 1'b0; habilita = 1'b0;
    step();
    chk("idle", {saida_m, ocupado_m, fim_m}, 3'b000);

    // 2: 8'hA5 with habilita held high
    entrada = 8'hA5; carregar = 1'b1; habilita = 1'b1;
    step();
    carregar = 1'b0; entrada = 8'h00;
    check_word("a5", 8'hA5);
    step();
    chk("a5_after", {saida_m, ocupado_m, fim_m}, 3'b000);

    // 3: 8'h3C with habilita every third cycle
    pat = 8'h3C; entrada = pat; carregar = 1'b1; habilita = 1'b0;
    step();
    carregar = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      chk("3c_slow", {saida_m, ocupado_m, fim_m}, {pat[7-(c-1)/3], 1'b1, 1'b0});
      habilita = ((c % 3) == 0);
      step();
    end
    habilita = 1'b0;
    chk("3c_fim", {saida_m, ocupado_m, fim_m}, 3'b001);
    step();
    chk("3c_after", {saida_m, ocupado_m, fim_m}, 3'b000);

    // 4: 8'h81 with carregar/8'hFF during bits 2..5 and on the final tick edge
    pat = 8'h81; entrada = pat; carregar = 1'b1; habilita = 1'b1;
    step();
    for (int c = 1; c <= 8; c++) begin
      chk("81_ign", {saida_m, ocupado_m, fim_m}, {pat[8-c], 1'b1, 1'b0});
      carregar = ((c >= 2 && c <= 5) || c == 8);
      entrada  = carregar ? 8'hFF : 8'h00;
      step();
    end
    carregar = 1'b0;
    chk("81_fim", {saida_m, ocupado_m, fim_m}, 3'b001);
    step();
    chk("81_noextra", {saida_m, ocupado_m, fim_m}, 3'b000);
    step();
    chk("81_noextra2", {saida_m, ocupado_m, fim_m}, 3'b000);

    // 5: 8'hF0 aborted by reset after three bits, then 8'h0F
    entrada = 8'hF0; carregar = 1'b1; habilita = 1'b1;
    step();
    carregar = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("f0_part", {saida_m, ocupado_m, fim_m}, 3'b110);
      if (c == 3) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    chk("f0_abort", {saida_m, ocupado_m, fim_m}, 3'b000);
    step();
    chk("f0_nofim", {saida_m, ocupado_m, fim_m}, 3'b000);
    entrada = 8'h0F; carregar = 1'b1;
    step();
    carregar = 1'b0;
    check_word("0f", 8'h0F);
    step();

    // 6: back-to-back 8'h01 then 8'h80 loaded on the fim cycle
    entrada = 8'h01; carregar = 1'b1; habilita = 1'b1;
    step();
    carregar = 1'b0;
    check_word("01", 8'h01);
    entrada = 8'h80; carregar = 1'b1;
    step();
    carregar = 1'b0;
    check_word("80", 8'h80);
    step();
    chk("80_after_msb", {saida_m, ocupado_m, fim_m}, 3'b000);
    chk("80_after_lsb", {saida_l, ocupado_l, fim_l}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
